// File: rtl/memcpy_cmd_queue.sv
// memcpy_cmd_queue: descriptor FIFO plus a two-state dispatcher for the memcpy
// engine. Descriptors are popped in IDLE. A zero-size descriptor retires
// locally with a cpl pulse. Any other descriptor is issued with a one-cycle
// mc_en pulse, and its operands are held until mc_done is seen in WAIT.
// Optional feature macro: MEMCPY_Q_STATS_EN (completion and byte counters).
module memcpy_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [63:0]              cmd_src,
  input  logic [63:0]              cmd_dst,
  input  logic [14:0]              cmd_size,
  output logic                     mc_en,
  output logic [63:0]              mc_src,
  output logic [63:0]              mc_dst,
  output logic [14:0]              mc_size,
  input  logic                     mc_done,
  output logic                     cpl,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     busy,
  output logic [31:0]              stat_copies,
  output logic [31:0]              stat_bytes
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [14:0] size;
  } desc_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  desc_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic             mc_en_q, mc_en_d;
  desc_t            mc_q, mc_d;
  logic             cpl_q, cpl_d;
  desc_t            head;
  logic             full, push, pop;

  // No full bypass: a pop in the same cycle does not reopen a full queue.
  assign full      = (count_q == FULL_CNT);
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  assign cmd_ready = !full;
  assign q_count   = count_q;
  assign busy      = (count_q != '0) || (state_q == WAIT);
  assign mc_en     = mc_en_q;
  assign mc_src    = mc_q.src;
  assign mc_dst    = mc_q.dst;
  assign mc_size   = mc_q.size;
  assign cpl       = cpl_q;

  // Pointer and occupancy update. Pointers wrap naturally because DEPTH is a
  // power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Descriptor storage. The data needs no reset because only the pointers
  // define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{src: cmd_src, dst: cmd_dst, size: cmd_size};
  end

  // Dispatcher next state. Zero-size descriptors never reach memcpy, because
  // memcpy would hang on a size of 0.
  always_comb begin
    state_d = state_q;
    mc_en_d = 1'b0;
    mc_d    = mc_q;
    cpl_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head.size == '0) begin
            cpl_d = 1'b1;
          end else begin
            mc_d    = head;
            mc_en_d = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mc_done) begin
          cpl_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset also clears queued descriptors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      mc_en_q  <= 1'b0;
      mc_q     <= '0;
      cpl_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      mc_en_q  <= mc_en_d;
      mc_q     <= mc_d;
      cpl_q    <= cpl_d;
    end
  end

`ifdef MEMCPY_Q_STATS_EN
  logic [31:0] stat_copies_q, stat_copies_d;
  logic [31:0] stat_bytes_q,  stat_bytes_d;

  // Count only completions accepted in WAIT. Both counters wrap modulo 2^32.
  always_comb begin
    stat_copies_d = stat_copies_q;
    stat_bytes_d  = stat_bytes_q;
    if ((state_q == WAIT) && mc_done) begin
      stat_copies_d = stat_copies_q + 32'd1;
      stat_bytes_d  = stat_bytes_q + {17'd0, mc_q.size};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_copies_q <= '0;
      stat_bytes_q  <= '0;
    end else begin
      stat_copies_q <= stat_copies_d;
      stat_bytes_q  <= stat_bytes_d;
    end
  end

  assign stat_copies = stat_copies_q;
  assign stat_bytes  = stat_bytes_q;
`else
  assign stat_copies = '0;
  assign stat_bytes  = '0;
`endif

endmodule

// File: tb/tb_memcpy_cmd_queue.sv
// Bench for memcpy_cmd_queue: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level queue model.
module tb_memcpy_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [63:0]   cmd_src, cmd_dst;
  logic [14:0]   cmd_size;
  logic          mc_en;
  logic [63:0]   mc_src, mc_dst;
  logic [14:0]   mc_size;
  logic          mc_done;
  logic          cpl;
  logic [CW-1:0] q_count;
  logic          busy;
  logic [31:0]   stat_copies, stat_bytes;

  memcpy_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_size(cmd_size),
    .mc_en(mc_en), .mc_src(mc_src), .mc_dst(mc_dst), .mc_size(mc_size),
    .mc_done(mc_done), .cpl(cpl), .q_count(q_count), .busy(busy),
    .stat_copies(stat_copies), .stat_bytes(stat_bytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [14:0] size;
  } d_t;

  d_t          mq[$];
  int          checks = 0;
  int          errors = 0;
  bit          m_wait, e_en, e_cpl;
  logic [63:0] e_src, e_dst;
  logic [14:0] e_size;
  logic [31:0] e_cop, e_byt;
  int          tmr;
  bit          hold, spur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0; e_en = 0; e_cpl = 0;
    e_src = '0; e_dst = '0; e_size = '0;
    e_cop = '0; e_byt = '0;
    tmr = 0; hold = 0; spur = 0;
  endtask

  // Apply the rules for one clock edge, using the pre-edge inputs.
  task automatic model_step();
    bit acc;
    d_t d;
    acc   = cmd_valid && (mq.size() < DEPTH);
    e_en  = 0;
    e_cpl = 0;
    if (m_wait) begin
      if (mc_done) begin
        e_cpl  = 1;
        m_wait = 0;
        e_cop  = e_cop + 32'd1;
        e_byt  = e_byt + 32'(e_size);
      end
    end else if (mq.size() > 0) begin
      d = mq.pop_front();
      if (d.size == 0) e_cpl = 1;
      else begin
        e_src = d.src; e_dst = d.dst; e_size = d.size;
        e_en = 1; m_wait = 1;
      end
    end
    if (acc) mq.push_back('{cmd_src, cmd_dst, cmd_size});
  endtask

  task automatic check_all();
    chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    chk("q_count",   64'(q_count),   64'(mq.size()));
    chk("busy",      64'(busy),      64'((mq.size() != 0) || m_wait));
    chk("mc_en",     64'(mc_en),     64'(e_en));
    chk("cpl",       64'(cpl),       64'(e_cpl));
    chk("mc_src",    mc_src,         e_src);
    chk("mc_dst",    mc_dst,         e_dst);
    chk("mc_size",   64'(mc_size),   64'(e_size));
`ifdef MEMCPY_Q_STATS_EN
    chk("stat_copies", 64'(stat_copies), 64'(e_cop));
    chk("stat_bytes",  64'(stat_bytes),  64'(e_byt));
`else
    chk("stat_copies", 64'(stat_copies), 64'd0);
    chk("stat_bytes",  64'(stat_bytes),  64'd0);
`endif
  endtask

  // One clock: drive mc_done from the memcpy stand-in, advance the model,
  // then check after the edge. The caller is at posedge+1 on entry and exit.
  task automatic cycle();
    mc_done = ((tmr == 1) && !hold) || (spur && !m_wait && (tmr == 0));
    model_step();
    @(posedge clk); #1;
    check_all();
    if ((tmr == 1) && !hold) tmr = 0;
    else if (tmr > 1) tmr--;
    if (e_en) tmr = $urandom_range(2, 5);
    spur = 0;
    mc_done = 0;
  endtask

  task automatic offer(input logic [63:0] s, input logic [63:0] d, input logic [14:0] z);
    cmd_valid = 1; cmd_src = s; cmd_dst = d; cmd_size = z;
    cycle();
    cmd_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_src = '0; cmd_dst = '0; cmd_size = '0; mc_done = 0;
    model_reset();
    #12;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_en",    64'(mc_en),     64'd0);
    chk("rst_cnt",   64'(q_count),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_cpl",   64'(cpl),       64'd0);
    chk("rst_src",   mc_src,         64'd0);
    @(posedge clk); #1;
    reset = 0;
    idle(2);

    // Single copy: mc_en two edges after the push edge.
    hold = 1;
    offer(64'h1000, 64'h2000, 15'd5);
    chk("single_en_early", 64'(mc_en), 64'd0);
    cycle();
    chk("single_en",   64'(mc_en),   64'd1);
    chk("single_src",  mc_src,       64'h1000);
    chk("single_dst",  mc_dst,       64'h2000);
    chk("single_size", 64'(mc_size), 64'd5);
    idle(4);
    chk("single_hold", 64'(mc_size), 64'd5);
    hold = 0;
    idle(6);
`ifdef MEMCPY_Q_STATS_EN
    chk("single_copies", 64'(stat_copies), 64'd1);
    chk("single_bytes",  64'(stat_bytes),  64'd5);
`endif

    // Fill and backpressure while memcpy withholds done.
    hold = 1;
    for (int i = 0; i < 5; i++) offer(64'h100 * i, 64'h9000 + i, 15'(i + 1));
    chk("full_ready", 64'(cmd_ready), 64'd0);
    chk("full_cnt",   64'(q_count),   64'd4);
    for (int i = 0; i < 3; i++) offer(64'hdead, 64'hbeef, 15'd7);
    chk("sixth_rejected", 64'(q_count), 64'd4);
    hold = 0;
    idle(40);

    // Zero-size descriptors are dropped locally.
    offer(64'h1, 64'h2, 15'd0);
    offer(64'h3, 64'h4, 15'd0);
    offer(64'h5, 64'h6, 15'd3);
    idle(12);

    // Push/pop at depth 2 and pointer wrap: 8 descriptors.
    hold = 1;
    for (int i = 0; i < 3; i++) offer(64'h7000 + i, 64'h8000 + i, 15'(10 + i));
    hold = 0;
    for (int i = 3; i < 8; i++) offer(64'h7000 + i, 64'h8000 + i, 15'(10 + i));
    idle(40);

    // Reset asserted between edges while in WAIT.
    hold = 1;
    offer(64'haaa, 64'hbbb, 15'd100);
    offer(64'hccc, 64'hddd, 15'd50);
    idle(2);
    #3 reset = 1;
    #1;
    chk("mid_rst_en",    64'(mc_en),     64'd0);
    chk("mid_rst_cnt",   64'(q_count),   64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    idle(1);
    offer(64'h4242, 64'h2424, 15'd9);
    idle(10);

    // Spurious done while idle and empty.
    spur = 1;
    cycle();
    idle(3);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      cmd_valid = ($urandom % 2) == 0;
      cmd_src   = {$urandom, $urandom};
      cmd_dst   = {$urandom, $urandom};
      r = $urandom % 8;
      if (r < 2)       cmd_size = 15'd0;
      else if (r == 2) cmd_size = 15'h7fff;
      else             cmd_size = 15'($urandom);
      hold = ($urandom % 8) == 0;
      spur = ($urandom % 10) == 0;
      cycle();
    end
    cmd_valid = 0;
    hold = 0;
    idle(60);
    chk("drain_cnt",  64'(q_count), 64'd0);
    chk("drain_busy", 64'(busy),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memcpy_cmd_queue.md
# memcpy_cmd_queue

Descriptor queue and dispatcher sitting directly upstream of the `memcpy` engine. It accepts copy descriptors (src, dst, size) from the serializer control path, buffers up to DEPTH of them, and issues them one at a time to `memcpy` with a one-cycle `en` pulse. It holds the operands stable until `memcpy` reports `done`, drops zero-size descriptors locally, and flags each completion.

## Interface
Parameters:
- DEPTH, 4: descriptor FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  descriptor offered.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_src  in  64  source byte address.
- cmd_dst  in  64  destination byte address.
- cmd_size  in  15  byte count.
- mc_en  out  1  start pulse to memcpy `en`.
- mc_src  out  64  to memcpy `src`.
- mc_dst  out  64  to memcpy `dst`.
- mc_size  out  15  to memcpy `size`.
- mc_done  in  1  memcpy `done`.
- cpl  out  1  one-cycle pulse per retired descriptor, including dropped zero-size ones.
- q_count  out  $clog2(DEPTH)+1  entries currently buffered.
- busy  out  1  high when q_count≠0 or state=WAIT.
- stat_copies  out  32  completed non-zero copies (see Configuration).
- stat_bytes  out  32  bytes copied, modulo 2^32 (see Configuration).

## Operation
- Reset values: cmd_ready=1, mc_en=0, mc_src=0, mc_dst=0, mc_size=0, cpl=0, q_count=0, busy=0, stat_*=0, state=IDLE, FIFO pointers=0.
- Push: accepted on an edge where cmd_valid && cmd_ready. The descriptor is written at the tail, and the tail pointer wraps modulo DEPTH.
- When full, cmd_ready=0 even if a pop happens in the same cycle. There is no same-cycle full bypass.
- A simultaneous push and pop when not full leaves q_count unchanged.
- The FSM has two states: IDLE and WAIT.
- IDLE, q_count≠0: pop the head.
  - If head size==0: discard it, pulse cpl next cycle, stay in IDLE. This path issues no mc_en, because memcpy would hang on size 0.
  - Otherwise: register mc_src, mc_dst and mc_size from the head, set mc_en=1 and move to WAIT.
- IDLE, q_count==0: mc_en=0, remain in IDLE.
- WAIT: mc_en returns to 0 after exactly one cycle.
  - mc_src, mc_dst and mc_size hold unchanged until the next issue, because memcpy reads size throughout the copy.
  - On mc_done=1: pulse cpl, update stats, move to IDLE.
- mc_done while in IDLE is ignored.
- Sizes are 15-bit unsigned, maximum 32767. stat_bytes adds zero-extended mc_size and wraps modulo 2^32. stat_copies also wraps.
- Reset mid-copy: all state clears immediately and queued descriptors are lost. memcpy shares the reset, so both restart idle.

## Timing
- Push accepted on edge E into an empty queue while IDLE:
  - q_count=1 after E.
  - mc_en is high for the single cycle after edge E+1.
- memcpy samples en at edge E+2.
- memcpy done is high for one cycle while it sits in its DONE state. This block sees mc_done at edge D and is IDLE after D.
- The next issue raises mc_en after edge D+1. memcpy is back in IDLE by then, so en is never lost or double-counted.
- cpl is registered: high for the cycle after edge D, or for the cycle after the pop edge for zero-size descriptors.
- Back-to-back zero-size descriptors retire at one per cycle.
- Minimum spacing between mc_en pulses is set by memcpy; at most one copy is outstanding.

## Configuration
- Macro: `MEMCPY_Q_STATS_EN`.
- Defined:
  - stat_copies increments by 1 on each mc_done accepted in WAIT.
  - stat_bytes accumulates mc_size on the same edge.
  - Both are reset to 0.
- Undefined: stat_copies and stat_bytes are tied to 0, no counter flops exist, and all other behaviour is identical.

## Test plan
- Single copy: push (src=0x1000, dst=0x2000, size=5).
  - Expect one mc_en pulse, 2 cycles after the push edge.
  - mc_* hold until mc_done; cpl pulses once.
  - With the macro: stat_copies=1, stat_bytes=5.
- Fill and backpressure, DEPTH=4, mc_done withheld: push 5 descriptors.
  - The first issues, the next 4 fill the queue, cmd_ready=0, and the 6th push is not accepted.
  - Release mc_done; the remaining descriptors issue in order and q_count decrements to 0.
- Zero-size drop: push sizes 0, 0, 3.
  - Two cpl pulses with no mc_en, then one mc_en with mc_size=3.
  - With the macro: stat_copies=1 and stat_bytes=3.
- Simultaneous push/pop at q_count=2: q_count stays 2, and the FIFO order across pointer wrap is preserved (8 pushes, DEPTH=4).
- Reset mid-WAIT: assert reset asynchronously between clock edges.
  - mc_en=0, q_count=0, busy=0 and cmd_ready=1 immediately.
  - A later push issues normally.
- Spurious mc_done while IDLE with empty queue: no cpl, no state change, stats unchanged.
